// File: rtl/bin_2_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_2_bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_2_bcd_digit.sv
// One BCD digit of the double-dabble chain: add 3 when >= 5, then shift left one place.
module bin_2_bcd_digit
    import bin_2_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] adj;

    always_comb begin
        adj = digit;
        if (digit >= DIGIT_W'(5)) begin
            adj = digit + DIGIT_W'(3);
        end
    end

    assign digit_next = {adj[DIGIT_W-2:0], carry_in};
    assign carry_out  = adj[DIGIT_W-1];

endmodule

// File: rtl/bin_2_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per cycle, valid/ready on both sides.
// Optional leading-zero blanking mask is built only when BIN_2_BCD_SEQ_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for an input, bin_ready_o high
// SHIFT | one add-3/shift step per cycle, MSB first
// DONE  | result held on bcd_o until bcd_ready_i
module bin_2_bcd_seq
    import bin_2_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int BCD_WIDTH = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [BIN_WIDTH-1:0]         bin_i,
    input  logic                         bin_valid_i,
    output logic                         bin_ready_o,
    output logic [BCD_WIDTH*DIGIT_W-1:0] bcd_o,
    output logic                         bcd_valid_o,
    input  logic                         bcd_ready_i,
    output logic                         overflow_o,
    output logic [BCD_WIDTH-1:0]         blank_o
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = BCD_WIDTH * DIGIT_W;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]     bcd_q, bcd_nxt;
    logic                 ovf_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_WIDTH:0]   carry;
    logic                 accept;
    logic                 last_shift;

    assign accept     = bin_valid_i && bin_ready_o;
    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bin_valid_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (bcd_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_ready_o = 1'b0;
        bcd_valid_o = 1'b0;
        case (state_q)
            IDLE:    bin_ready_o = 1'b1;
            DONE:    bcd_valid_o = 1'b1;
            default: ;
        endcase
    end

    // The top bit of the captured input feeds digit 0; carries ripple upward.
    assign carry[0] = bin_q[BIN_WIDTH-1];

    for (genvar d = 0; d < BCD_WIDTH; d++) begin : g_digit
        bin_2_bcd_digit u_digit (
            .digit      (bcd_q[d*DIGIT_W +: DIGIT_W]),
            .carry_in   (carry[d]),
            .digit_next (bcd_nxt[d*DIGIT_W +: DIGIT_W]),
            .carry_out  (carry[d+1])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_W'(BIN_WIDTH);
        end else if (state_q == SHIFT) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_nxt;
            ovf_q <= ovf_q | carry[BCD_WIDTH];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bcd_o      = bcd_q;
    assign overflow_o = ovf_q;

`ifdef BIN_2_BCD_SEQ_BLANK_EN
    logic [BCD_WIDTH-1:0] blank_q, blank_d;

    // Digit d blanks when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_d = '0;
        for (int d = 1; d < BCD_WIDTH; d++) begin
            blank_d[d] = ~|(bcd_nxt >> (DIGIT_W * d));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blank_q <= '0;
        end else if (last_shift) begin
            blank_q <= blank_d;
        end else if (state_q != DONE) begin
            blank_q <= '0;
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// Bench for bin_2_bcd_seq: a 16-bit/5-digit and a 10-bit/3-digit instance against an arithmetic model.
module tb_bin_2_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [15:0] bin_a;
    logic        valid_a, ready_a, bvalid_a, bready_a, ovf_a;
    logic [19:0] bcd_a;
    logic [4:0]  blank_a;

    logic [9:0]  bin_b;
    logic        valid_b, ready_b, bvalid_b, bready_b, ovf_b;
    logic [11:0] bcd_b;
    logic [2:0]  blank_b;

    int n_tests = 0;
    int n_fail  = 0;

    bin_2_bcd_seq #(.BIN_WIDTH(16), .BCD_WIDTH(5)) u_dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bin_i       (bin_a),
        .bin_valid_i (valid_a),
        .bin_ready_o (ready_a),
        .bcd_o       (bcd_a),
        .bcd_valid_o (bvalid_a),
        .bcd_ready_i (bready_a),
        .overflow_o  (ovf_a),
        .blank_o     (blank_a)
    );

    bin_2_bcd_seq #(.BIN_WIDTH(10), .BCD_WIDTH(3)) u_dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bin_i       (bin_b),
        .bin_valid_i (valid_b),
        .bin_ready_o (ready_b),
        .bcd_o       (bcd_b),
        .bcd_valid_o (bvalid_b),
        .bcd_ready_i (bready_b),
        .overflow_o  (ovf_b),
        .blank_o     (blank_b)
    );

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] ref_bcd(input longint v, input int nd);
        logic [19:0] r = '0;
        longint      x = v % pow10(nd);
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input longint v, input int nd);
        logic [4:0] b = '0;
`ifdef BIN_2_BCD_SEQ_BLANK_EN
        longint x = v % pow10(nd);
        for (int d = 1; d < nd; d++) b[d] = ((x / pow10(d)) == 0);
`endif
        return b;
    endfunction

    task automatic run_a(input logic [15:0] v, input int hold, output logic [19:0] bcd,
                         output logic ovf, output logic [4:0] blank, output int lat);
        @(negedge clk);
        bin_a = v; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; bin_a = 16'($urandom);
        lat = 1;
        while (!bvalid_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        bcd = bcd_a; ovf = ovf_a; blank = blank_a;
        repeat (hold) @(negedge clk);
        bready_a = 1'b1;
        @(negedge clk);
        bready_a = 1'b0;
    endtask

    task automatic run_b(input logic [9:0] v, input int hold, output logic [11:0] bcd,
                         output logic ovf, output logic [2:0] blank, output int lat);
        @(negedge clk);
        bin_b = v; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0; bin_b = 10'($urandom);
        lat = 1;
        while (!bvalid_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        bcd = bcd_b; ovf = ovf_b; blank = blank_b;
        repeat (hold) @(negedge clk);
        bready_b = 1'b1;
        @(negedge clk);
        bready_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (ready_a !== 1'b1)  begin n_fail++; $display("FAIL reset_ready_a got %b want 1", ready_a); end
        n_tests++; if (bvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %b want 0", bvalid_a); end
        n_tests++; if (bcd_a !== 20'h0)   begin n_fail++; $display("FAIL reset_bcd_a got %h want 0", bcd_a); end
        n_tests++; if (ovf_a !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf_a got %b want 0", ovf_a); end
        n_tests++; if (blank_a !== 5'b0)  begin n_fail++; $display("FAIL reset_blank_a got %b want 0", blank_a); end
        n_tests++; if (ready_b !== 1'b1)  begin n_fail++; $display("FAIL reset_ready_b got %b want 1", ready_b); end
        n_tests++; if (bcd_b !== 12'h0)   begin n_fail++; $display("FAIL reset_bcd_b got %h want 0", bcd_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] vals [4] = '{16'd0, 16'd65535, 16'd9, 16'd42};
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_a(vals[i], 0, bcd, ovf, blank, lat);
            n_tests++; if (bcd !== ref_bcd(vals[i], 5)) begin n_fail++; $display("FAIL dir_bcd v=%0d got %h want %h", vals[i], bcd, ref_bcd(vals[i], 5)); end
            n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL dir_ovf v=%0d got %b want 0", vals[i], ovf); end
            n_tests++; if (blank !== ref_blank(vals[i], 5)) begin n_fail++; $display("FAIL dir_blank v=%0d got %b want %b", vals[i], blank, ref_blank(vals[i], 5)); end
            n_tests++; if (lat != 17) begin n_fail++; $display("FAIL dir_latency v=%0d got %0d want 17", vals[i], lat); end
        end
    endtask

    task automatic test_narrow();
        logic [9:0]  vals [5] = '{10'd1000, 10'd999, 10'd1023, 10'd0, 10'd7};
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_blank;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_b(vals[i], 1, bcd, ovf, blank, lat);
            exp_bcd   = ref_bcd(vals[i], 3);
            exp_blank = ref_blank(vals[i], 3);
            n_tests++; if (bcd !== exp_bcd[11:0]) begin n_fail++; $display("FAIL nar_bcd v=%0d got %h want %h", vals[i], bcd, exp_bcd[11:0]); end
            n_tests++; if (ovf !== (vals[i] > 999)) begin n_fail++; $display("FAIL nar_ovf v=%0d got %b want %b", vals[i], ovf, vals[i] > 999); end
            n_tests++; if (blank !== exp_blank[2:0]) begin n_fail++; $display("FAIL nar_blank v=%0d got %b want %b", vals[i], blank, exp_blank[2:0]); end
            n_tests++; if (lat != 11) begin n_fail++; $display("FAIL nar_latency v=%0d got %0d want 11", vals[i], lat); end
        end
    endtask

    task automatic test_random();
        logic [15:0] va;
        logic [9:0]  vb;
        logic [19:0] bcd, exp_bcd;
        logic [11:0] bcdb;
        logic [4:0]  blank, exp_blank;
        logic [2:0]  blankb;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            va = 16'($urandom);
            if (i % 4 == 0) va = 16'($urandom_range(0, 120));
            run_a(va, $urandom_range(0, 3), bcd, ovf, blank, lat);
            n_tests++; if (bcd !== ref_bcd(va, 5)) begin n_fail++; $display("FAIL rnd_bcd_a v=%0d got %h want %h", va, bcd, ref_bcd(va, 5)); end
            n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_ovf_a v=%0d got %b want 0", va, ovf); end
            n_tests++; if (blank !== ref_blank(va, 5)) begin n_fail++; $display("FAIL rnd_blank_a v=%0d got %b want %b", va, blank, ref_blank(va, 5)); end
        end
        for (int i = 0; i < 25; i++) begin
            vb = 10'($urandom);
            run_b(vb, $urandom_range(0, 2), bcdb, ovf, blankb, lat);
            exp_bcd   = ref_bcd(vb, 3);
            exp_blank = ref_blank(vb, 3);
            n_tests++; if (bcdb !== exp_bcd[11:0]) begin n_fail++; $display("FAIL rnd_bcd_b v=%0d got %h want %h", vb, bcdb, exp_bcd[11:0]); end
            n_tests++; if (ovf !== (vb > 999)) begin n_fail++; $display("FAIL rnd_ovf_b v=%0d got %b want %b", vb, ovf, vb > 999); end
            n_tests++; if (blankb !== exp_blank[2:0]) begin n_fail++; $display("FAIL rnd_blank_b v=%0d got %b want %b", vb, blankb, exp_blank[2:0]); end
        end
    endtask

    task automatic test_hold();
        logic [15:0] v;
        int          lat;
        v = 16'($urandom);
        @(negedge clk);
        bin_a = v; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        lat = 1;
        while (!bvalid_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            bin_a = 16'($urandom); valid_a = ~valid_a;
            @(negedge clk);
            n_tests++; if (bcd_a !== ref_bcd(v, 5)) begin n_fail++; $display("FAIL hold_bcd cyc=%0d got %h want %h", i, bcd_a, ref_bcd(v, 5)); end
            n_tests++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_ready cyc=%0d got %b want 0", i, ready_a); end
            n_tests++; if (bvalid_a !== 1'b1) begin n_fail++; $display("FAIL hold_valid cyc=%0d got %b want 1", i, bvalid_a); end
        end
        // Request pending on the release edge must not be taken in that same cycle.
        valid_a = 1'b1; bready_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; bready_a = 1'b0;
        n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", ready_a); end
        n_tests++; if (bvalid_a !== 1'b0) begin n_fail++; $display("FAIL release_valid got %b want 0", bvalid_a); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
        logic [15:0] v;
        int          lat;
        @(negedge clk);
        bin_a = 16'hFFFF; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bcd_a !== 20'h0)   begin n_fail++; $display("FAIL midrst_bcd got %h want 0", bcd_a); end
        n_tests++; if (ready_a !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready got %b want 1", ready_a); end
        n_tests++; if (bvalid_a !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bvalid_a); end
        n_tests++; if (ovf_a !== 1'b0)    begin n_fail++; $display("FAIL midrst_ovf got %b want 0", ovf_a); end
        n_tests++; if (blank_a !== 5'b0)  begin n_fail++; $display("FAIL midrst_blank got %b want 0", blank_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL postrst_ready got %b want 1", ready_a); end
        v = 16'($urandom);
        run_a(v, 0, bcd, ovf, blank, lat);
        n_tests++; if (bcd !== ref_bcd(v, 5)) begin n_fail++; $display("FAIL postrst_bcd v=%0d got %h want %h", v, bcd, ref_bcd(v, 5)); end
        n_tests++; if (lat != 17) begin n_fail++; $display("FAIL postrst_latency got %0d want 17", lat); end
    endtask

    initial begin
        rst_n = 1'b0;
        bin_a = '0; valid_a = 1'b0; bready_a = 1'b0;
        bin_b = '0; valid_b = 1'b0; bready_b = 1'b0;
        test_reset();
        test_directed();
        test_narrow();
        test_random();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
